// File: rtl/cim_pkg.sv
// Shared constants and FSM state type for the CIM PE output path.
// No logic, no latency; no flow control.
// Used by psum_accumulator and psum_quant (the latter only when PSUM_QUANT_EN is set).
package cim_pkg;

    localparam int PSUM_W = 14;
    localparam int ACC_W  = 18;
    localparam int NT_W   = 4;
    localparam int QSHIFT = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } acc_state_t;

endpackage

// File: rtl/psum_quant.sv
// Round-half-up, right-shift by QSHIFT, saturate to 8b; zero-extended to ACC_W.
// Purely combinational, zero latency; no flow control.
// Compiled only with PSUM_QUANT_EN defined, where psum_accumulator instantiates it.
`ifdef PSUM_QUANT_EN
module psum_quant
    import cim_pkg::*;
(
    input  logic [ACC_W-1:0] sum_in,
    output logic [ACC_W-1:0] q_out
);

    localparam logic [ACC_W:0] RND = (ACC_W+1)'(1) << (QSHIFT - 1);

    logic [ACC_W:0] rounded;
    logic [ACC_W:0] shifted;
    logic [7:0]     sat8;

    // One extra bit keeps the rounding add from wrapping at full scale.
    always_comb begin
        rounded = {1'b0, sum_in} + RND;
        shifted = rounded >> QSHIFT;
        sat8    = (shifted > (ACC_W+1)'(255)) ? 8'hFF : shifted[7:0];
        q_out   = {{(ACC_W-8){1'b0}}, sat8};
    end

endmodule
`endif

// File: rtl/psum_accumulator.sv
// Accumulates 1..16 PE partial sums into one output-neuron value; PSUM_QUANT_EN adds round/shift/saturate.
// out_valid rises one cycle after the last accepted psum.
// psum_ready only in ACCUM; result held in OUTPUT until out_ready, with start taken on the same cycle.
module psum_accumulator
    import cim_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NT_W-1:0]   num_tiles_m1,
    input  logic              psum_valid,
    input  logic [PSUM_W-1:0] psum_in,
    output logic              psum_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              busy
);

    acc_state_t        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [NT_W-1:0]   tile_cnt_q, tile_cnt_d;
    logic [NT_W-1:0]   tiles_lim_q, tiles_lim_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  acc_out_q, acc_out_d;

    logic [ACC_W-1:0]  final_sum;
    logic [ACC_W-1:0]  result;

    assign final_sum = acc_q + ACC_W'(psum_in);

`ifdef PSUM_QUANT_EN
    psum_quant u_quant (
        .sum_in (final_sum),
        .q_out  (result)
    );
`else
    assign result = final_sum;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tile_cnt_d  = tile_cnt_q;
        tiles_lim_d = tiles_lim_q;
        out_valid_d = out_valid_q;
        acc_out_d   = acc_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d       = '0;
                    tile_cnt_d  = '0;
                    tiles_lim_d = num_tiles_m1;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                if (psum_valid) begin
                    acc_d = final_sum;
                    if (tile_cnt_q == tiles_lim_q) begin
                        acc_out_d   = result;
                        out_valid_d = 1'b1;
                        state_d     = OUTPUT;
                    end else begin
                        tile_cnt_d = tile_cnt_q + 1'b1;
                    end
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    // Back-to-back restart: the next job begins without an IDLE bubble.
                    if (start) begin
                        acc_d       = '0;
                        tile_cnt_d  = '0;
                        tiles_lim_d = num_tiles_m1;
                        state_d     = ACCUM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tile_cnt_q  <= '0;
            tiles_lim_q <= '0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tile_cnt_q  <= tile_cnt_d;
            tiles_lim_q <= tiles_lim_d;
            out_valid_q <= out_valid_d;
            acc_out_q   <= acc_out_d;
        end
    end

    assign psum_ready = (state_q == ACCUM);
    assign busy       = (state_q != IDLE);
    assign out_valid  = out_valid_q;
    assign acc_out    = acc_out_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator; expected results queued at start, popped on each output handshake.
// Works with or without PSUM_QUANT_EN (the reference model follows the same macro).
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  num_tiles_m1;
    logic        psum_valid;
    logic [13:0] psum_in;
    logic        psum_ready;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] acc_out;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    psum_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_tiles_m1 (num_tiles_m1),
        .psum_valid   (psum_valid),
        .psum_in      (psum_in),
        .psum_ready   (psum_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .acc_out      (acc_out),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input int unsigned s);
`ifdef PSUM_QUANT_EN
        int unsigned q;
        q = (s + 512) >> 10;
        return (q > 255) ? 255 : q;
`else
        return s % (1 << 18);
`endif
    endfunction

    // Output monitor: every accepted result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", acc_out, 32'hFFFF_FFFF);
            else check("result", acc_out, exp_q.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 of the start edge.
    task automatic start_acc(input int m1, input int unsigned exp_sum, input bit push);
        start        = 1'b1;
        num_tiles_m1 = 4'(m1);
        if (push) exp_q.push_back(model(exp_sum));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Holds valid until an edge where psum_ready is high; returns at posedge+1 of that transfer.
    task automatic send_psum(input int v);
        int n = 0;
        psum_valid = 1'b1;
        psum_in    = 14'(v);
        forever begin
            @(negedge clk);
            if (psum_ready) begin
                @(posedge clk); #1;
                break;
            end
            n++;
            if (n > 100) begin
                check("psum_accept_timeout", 0, 1);
                break;
            end
        end
        psum_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_tiles_m1 = '0;
        psum_valid = 1'b0; psum_in = '0; out_ready = 1'b0;
        #12;
        check("rst_psum_ready", psum_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_acc_out", acc_out, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Single tile
        start_acc(0, 14400, 1);
        check("single_busy", busy, 1);
        check("single_ready", psum_ready, 1);
        send_psum(14400);
        check("single_valid_next", out_valid, 1);
        check("single_ready_out", psum_ready, 0);
        wait_done("single_drain");
        check("single_idle", busy, 0);

        // Sixteen beats with valid gaps
        start_acc(15, 230400, 1);
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < (i % 3); g++) begin
                @(negedge clk);
                check("max_gap_ready", psum_ready, 1);
                check("max_no_early", out_valid, 0);
                @(posedge clk); #1;
            end
            send_psum(14400);
            if (i < 15) check("max_not_done", out_valid, 0);
        end
        check("max_done", out_valid, 1);
        wait_done("max_drain");

        // Output backpressure with a pending psum, then back-to-back restart
        out_ready = 1'b0;
        start_acc(1, 3000, 1);
        send_psum(1000);
        send_psum(2000);
        psum_valid = 1'b1;
        psum_in    = 14'd55;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_stable", acc_out, model(3000));
            check("bp_ready", psum_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        start_acc(0, 55, 1);
        check("b2b_busy", busy, 1);
        check("b2b_ready", psum_ready, 1);
        send_psum(55);
        wait_done("b2b_drain");

        // Asynchronous reset mid-accumulation
        start_acc(3, 0, 0);
        send_psum(100);
        send_psum(100);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", psum_ready, 0);
        check("arst_valid", out_valid, 0);
        check("arst_acc_out", acc_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_acc(0, 7, 1);
        send_psum(7);
        wait_done("arst_drain");

        // start in ACCUM must not reload the tile limit
        start_acc(1, 11, 1);
        send_psum(5);
        start_acc(7, 0, 0);
        send_psum(6);
        wait_done("ign_drain");
        check("ign_idle", busy, 0);

        // Rounding boundaries and partial-range sums
        start_acc(0, 1536, 1);
        send_psum(1536);
        wait_done("q1536_drain");
        start_acc(0, 1535, 1);
        send_psum(1535);
        wait_done("q1535_drain");
        start_acc(3, 57600, 1);
        for (int i = 0; i < 4; i++) send_psum(14400);
        wait_done("q57600_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
